// File: rtl/red_pkg.sv
// Shared types and width helpers for the lane-reduction pipeline.
// The sideband bundle rides alongside each beat through every stage.
package red_pkg;

    typedef struct packed {
        logic vld;
        logic sgn;
        logic acc_en;
        logic acc_clr;
    } side_t;

    function automatic int tree_lvls(input int lanes);
        return $clog2(lanes);
    endfunction

    // Exact width of the full lane sum: lane adders add one bit, each tree level one more.
    function automatic int sum_w(input int lane_w, input int lanes);
        return lane_w + 1 + $clog2(lanes);
    endfunction

endpackage

// File: rtl/red_tree_level.sv
// One registered pairwise-add level of the reduction tree (1 cycle), sign/zero-extending per beat.
// Holds all state while i_en is low so a downstream stall freezes the level.
module red_tree_level
    import red_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int IN_W = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_en,
    input  side_t                            i_side,
    input  logic [N_IN*IN_W-1:0]             i_dat,
    output side_t                            o_side,
    output logic [(N_IN/2)*(IN_W+1)-1:0]     o_dat
);
    localparam int N_OUT = N_IN / 2;
    localparam int OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] w_sum;
    side_t                  r_side;
    logic [N_OUT*OUT_W-1:0] r_dat;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        logic [IN_W-1:0] w_a;
        logic [IN_W-1:0] w_b;
        assign w_a = i_dat[(2*j)*IN_W +: IN_W];
        assign w_b = i_dat[(2*j+1)*IN_W +: IN_W];
        assign w_sum[j*OUT_W +: OUT_W] = {i_side.sgn & w_a[IN_W-1], w_a}
                                       + {i_side.sgn & w_b[IN_W-1], w_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_side <= '0;
            r_dat  <= '0;
        end else if (i_en) begin
            r_side <= i_side;
            r_dat  <= w_sum;
        end
    end

    assign o_side = r_side;
    assign o_dat  = r_dat;

endmodule

// File: rtl/reduction_pipe.sv
// Pipelined lane reduction of rs+rt with optional accumulate; latency 2+log2(LANES), 1 beat/cycle.
// Global stall: a held output freezes every stage and drops in_ready.
module reduction_pipe
    import red_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic              sgn,
    input  logic              acc_en,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd,
    output logic              ovf
);
    localparam int LANES     = DATA_W / LANE_W;
    localparam int TREE_LVLS = tree_lvls(LANES);
    localparam int SUM_W     = sum_w(LANE_W, LANES);
    localparam int S0_W      = LANE_W + 1;

    logic w_stall;
    logic w_adv;

    logic              r_out_vld;
    logic [DATA_W-1:0] r_rd;
    logic              r_ovf;
    logic [DATA_W-1:0] r_acc;

    assign w_stall   = r_out_vld & ~out_ready;
    assign w_adv     = ~w_stall;
    assign in_ready  = w_adv;
    assign out_valid = r_out_vld;
    assign rd        = r_rd;
    assign ovf       = r_ovf;

    side_t                 w_in_side;
    side_t                 r_s0_side;
    logic [LANES*S0_W-1:0] w_s0_sum;
    logic [LANES*S0_W-1:0] r_s0_dat;

    assign w_in_side = {in_valid, sgn, acc_en, acc_clr};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] w_a;
        logic [LANE_W-1:0] w_b;
        assign w_a = rs[i*LANE_W +: LANE_W];
        assign w_b = rt[i*LANE_W +: LANE_W];
        assign w_s0_sum[i*S0_W +: S0_W] = {sgn & w_a[LANE_W-1], w_a}
                                        + {sgn & w_b[LANE_W-1], w_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_side <= '0;
            r_s0_dat  <= '0;
        end else if (w_adv) begin
            r_s0_side <= w_in_side;
            r_s0_dat  <= w_s0_sum;
        end
    end

    // Each level halves the value count and widens by one bit.
    for (genvar k = 0; k < TREE_LVLS; k++) begin : g_lvl
        localparam int N_IN = LANES >> k;
        localparam int IN_W = S0_W + k;
        side_t                             w_side_in;
        side_t                             w_side_out;
        logic [N_IN*IN_W-1:0]              w_in;
        logic [(N_IN/2)*(IN_W+1)-1:0]      w_out;

        if (k == 0) begin : g_first
            assign w_side_in = r_s0_side;
            assign w_in      = r_s0_dat;
        end else begin : g_next
            assign w_side_in = g_lvl[k-1].w_side_out;
            assign w_in      = g_lvl[k-1].w_out;
        end

        red_tree_level #(
            .N_IN (N_IN),
            .IN_W (IN_W)
        ) u_level (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_side (w_side_in),
            .i_dat  (w_in),
            .o_side (w_side_out),
            .o_dat  (w_out)
        );
    end

    side_t             w_fin_side;
    logic [SUM_W-1:0]  w_tree_sum;
    logic [DATA_W-1:0] w_ext;
    logic              w_trunc_ovf;

    assign w_fin_side = g_lvl[TREE_LVLS-1].w_side_out;
    assign w_tree_sum = g_lvl[TREE_LVLS-1].w_out;

    if (SUM_W < DATA_W) begin : g_sext
        assign w_ext       = {{(DATA_W-SUM_W){w_fin_side.sgn & w_tree_sum[SUM_W-1]}}, w_tree_sum};
        assign w_trunc_ovf = 1'b0;
    end else if (SUM_W == DATA_W) begin : g_exact
        assign w_ext       = w_tree_sum;
        assign w_trunc_ovf = 1'b0;
    end else begin : g_trunc
        // Dropped bits plus the kept MSB must all match for a lossless signed truncation.
        logic [SUM_W-DATA_W:0] w_top;
        assign w_top       = w_tree_sum[SUM_W-1:DATA_W-1];
        assign w_ext       = w_tree_sum[DATA_W-1:0];
        assign w_trunc_ovf = w_fin_side.sgn ? ~((&w_top) | ~(|w_top))
                                            : (|w_top[SUM_W-DATA_W:1]);
    end

    logic [DATA_W:0]   w_add;
    logic              w_add_ovf;
    logic [DATA_W-1:0] w_rd_nxt;
    logic              w_ovf_nxt;
    logic [DATA_W-1:0] w_acc_nxt;

    assign w_add     = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_add_ovf = w_fin_side.sgn
                     ? ((r_acc[DATA_W-1] == w_ext[DATA_W-1]) && (w_add[DATA_W-1] != r_acc[DATA_W-1]))
                     : w_add[DATA_W];

    always_comb begin
        w_rd_nxt  = w_ext;
        w_ovf_nxt = w_trunc_ovf;
        w_acc_nxt = r_acc;
        if (w_fin_side.acc_en) begin
            if (!w_fin_side.acc_clr) begin
                w_rd_nxt  = w_add[DATA_W-1:0];
                w_ovf_nxt = w_trunc_ovf | w_add_ovf;
            end
            w_acc_nxt = w_rd_nxt;
        end else if (w_fin_side.acc_clr) begin
            w_acc_nxt = '0;
        end
    end

    // Bubbles advance the valid bit only; result and accumulator stay untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_rd      <= '0;
            r_ovf     <= 1'b0;
            r_acc     <= '0;
        end else if (w_adv) begin
            r_out_vld <= w_fin_side.vld;
            if (w_fin_side.vld) begin
                r_rd  <= w_rd_nxt;
                r_ovf <= w_ovf_nxt;
                r_acc <= w_acc_nxt;
            end
        end
    end

endmodule
